// File: rtl/usb_tx_line_encoder_if.sv
// usb_tx_line_encoder_if: FSM-to-encoder bundle; master drives load_enable/data_pts/state_val, slave drives dplus/dminus/byte_complete/tx_active/tx_error
interface usb_tx_line_encoder_if;
  logic       load_enable;
  logic [7:0] data_pts;
  logic [2:0] state_val;
  logic       dplus;
  logic       dminus;
  logic       byte_complete;
  logic       tx_active;
  logic       tx_error;
  modport master (
    output load_enable, data_pts, state_val,
    input  dplus, dminus, byte_complete, tx_active, tx_error
  );
  modport slave (
    input  load_enable, data_pts, state_val,
    output dplus, dminus, byte_complete, tx_active, tx_error
  );
endinterface

// File: rtl/usb_tx_line_encoder.sv
// usb_tx_line_encoder: USB FS serialiser with bit stuffing, NRZI and EOP; ports clk, rst (sync, high), bus (slave: load/data/state in, line/handshake out)
module usb_tx_line_encoder #(
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input logic                   clk,
  input logic                   rst,
  usb_tx_line_encoder_if.slave  bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT   = 3'd1;
  localparam logic [2:0] STUFF   = 3'd2;
  localparam logic [2:0] EOP_SE0 = 3'd3;
  localparam logic [2:0] EOP_J   = 3'd4;
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int SW = $clog2(EOP_SE0_BITS + 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          eop_q, eop_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          line_q, line_d;
  logic [SW-1:0] se0_q, se0_d;
  logic          bc_q, bc_d;
  logic          err_q, err_d;

  logic          active, shifting, take, last, stuff_now, advance;
  logic [OW-1:0] ones_n;

  assign active    = state_q != IDLE;
  assign shifting  = state_q == SHIFT || state_q == STUFF;
  assign take      = shifting && bus.load_enable;
  assign last      = cnt_q == (phase_q == 2'd2 ? 4'd8 : 4'd7);
  assign ones_n    = shift_q[0] ? ones_q + 1'b1 : '0;
  assign stuff_now = state_q == SHIFT && last && ones_n == OW'(STUFF_LIMIT);
  assign advance   = last && (state_q == STUFF || (state_q == SHIFT && !stuff_now));

  // line_q is the NRZI level (1 = J) of the bit currently on the wire
  always_comb begin
    state_d     = state_q;
    cnt_d       = active ? (last ? 4'd0 : cnt_q + 4'd1) : cnt_q;
    phase_d     = active && last ? (phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1) : phase_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    hold_d      = take ? bus.data_pts : hold_q;
    hold_full_d = hold_full_q | take;
    eop_d       = eop_q | (active && bus.state_val == 3'd6);
    ones_d      = state_q == SHIFT && last ? (stuff_now ? '0 : ones_n) : ones_q;
    line_d      = stuff_now ? ~line_q : line_q;
    se0_d       = se0_q;
    bc_d        = 1'b0;
    err_d       = 1'b0;
    if (stuff_now) state_d = STUFF;
    if (state_q == IDLE && bus.load_enable) begin
      state_d = SHIFT;
      shift_d = bus.data_pts;
      idx_d   = 3'd0;
      cnt_d   = 4'd0;
      phase_d = 2'd0;
      ones_d  = '0;
      line_d  = bus.data_pts[0];
    end
    if (advance) begin
      if (idx_q != 3'd7) begin
        state_d = SHIFT;
        idx_d   = idx_q + 3'd1;
        shift_d = shift_q >> 1;
        line_d  = shift_q[1] ? line_q : ~line_q;
        bc_d    = idx_q == 3'd6 && !hold_full_d;
      end else if (hold_full_d) begin
        state_d     = SHIFT;
        idx_d       = 3'd0;
        shift_d     = hold_d;
        hold_full_d = 1'b0;
        line_d      = hold_d[0] ? line_q : ~line_q;
        bc_d        = 1'b1;
      end else begin
        state_d = EOP_SE0;
        se0_d   = '0;
        err_d   = !eop_d;
      end
    end
    if (state_q == EOP_SE0 && last) begin
      se0_d   = se0_q + 1'b1;
      state_d = se0_q == SW'(EOP_SE0_BITS - 1) ? EOP_J : EOP_SE0;
    end
    if (state_q == EOP_J && last) begin
      state_d = IDLE;
      eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_q     <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      eop_q       <= 1'b0;
      ones_q      <= '0;
      line_q      <= 1'b0;
      se0_q       <= '0;
      bc_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      eop_q       <= eop_d;
      ones_q      <= ones_d;
      line_q      <= line_d;
      se0_q       <= se0_d;
      bc_q        <= bc_d;
      err_q       <= err_d;
    end
  end

  assign bus.dplus         = shifting ? line_q : state_q != EOP_SE0;
  assign bus.dminus        = shifting && !line_q;
  assign bus.tx_active     = active;
  assign bus.byte_complete = bc_q;
  assign bus.tx_error      = err_q;
endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// tb_usb_tx_line_encoder: randomized scenarios checked against a bit-stream reference model
module tb_usb_tx_line_encoder;
  localparam int STUFF_N = 6;
  localparam int SE0_N   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  logic [7:0] bytes_q[$];
  logic [4:0] exp_q[$];

  usb_tx_line_encoder_if bus ();
  usb_tx_line_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Expected {dplus,dminus,tx_active,byte_complete,tx_error} per cycle, cycle 0 = first cycle after the load edge
  task automatic build_model(input bit eop, output int bc_exp);
    int  kind[$];
    bit  lvl[$];
    int  bcs[$];
    bit  line, v, is_bc;
    int  ones, n, err_sym, len;
    logic [4:0] e;
    line = 1'b1;
    ones = 0;
    n = bytes_q.size();
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        v = bytes_q[i][b];
        if ((b == 7 && (i == 0 || i == n - 1)) || (b == 0 && i > 0)) bcs.push_back(kind.size());
        if (!v) line = ~line;
        kind.push_back(0);
        lvl.push_back(line);
        ones = v ? ones + 1 : 0;
        if (ones == STUFF_N) begin
          line = ~line;
          kind.push_back(0);
          lvl.push_back(line);
          ones = 0;
        end
      end
    end
    err_sym = eop ? -1 : kind.size();
    for (int s = 0; s < SE0_N; s++) begin kind.push_back(1); lvl.push_back(1'b0); end
    kind.push_back(2);
    lvl.push_back(1'b1);
    bc_exp = bcs.size();
    exp_q.delete();
    for (int s = 0; s < kind.size(); s++) begin
      len = (s % 3 == 2) ? 9 : 8;
      is_bc = 1'b0;
      foreach (bcs[j]) if (bcs[j] == s) is_bc = 1'b1;
      for (int c = 0; c < len; c++) begin
        e[4] = kind[s] == 1 ? 1'b0 : lvl[s];
        e[3] = kind[s] == 0 ? ~lvl[s] : 1'b0;
        e[2] = 1'b1;
        e[1] = c == 0 && is_bc;
        e[0] = c == 0 && s == err_sym;
        exp_q.push_back(e);
      end
    end
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'b10000);
  endtask

  task automatic run_packet(input string name, input bit eop, input int dly, input int abort_at);
    int n, nxt, wait_c, bc_seen, bc_exp;
    bit req;
    logic [4:0] got;
    n = bytes_q.size();
    build_model(eop, bc_exp);
    nxt = 1;
    wait_c = -1;
    bc_seen = 0;
    req = eop && n == 1;
    bus.state_val = 3'd0;
    bus.data_pts = bytes_q[0];
    bus.load_enable = 1'b1;
    @(posedge clk); #1;
    bus.load_enable = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = {bus.dplus, bus.dminus, bus.tx_active, bus.byte_complete, bus.tx_error};
      checks++;
      if (got !== exp_q[k]) begin
        fails++;
        $display("FAIL %s cycle %0d: dp,dm,act,bc,err got %b expected %b", name, k, got, exp_q[k]);
      end
      if (bus.byte_complete === 1'b1) bc_seen++;
      bus.load_enable = 1'b0;
      bus.state_val = req ? 3'd6 : 3'd0;
      req = 1'b0;
      if (bus.byte_complete === 1'b1 && nxt < n) wait_c = dly < 0 ? int'($urandom_range(0, 4)) : dly;
      if (wait_c == 0) begin
        bus.data_pts = bytes_q[nxt];
        bus.load_enable = 1'b1;
        nxt++;
        wait_c = -1;
        req = eop && nxt == n;
      end else if (wait_c > 0) wait_c--;
      if (exp_q[k][4:3] == 2'b00 && nxt == n) begin
        bus.load_enable = 1'b1;
        bus.data_pts = 8'($urandom);
      end
      if (k == abort_at) begin
        bus.load_enable = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        got = {bus.dplus, bus.dminus, bus.tx_active, bus.byte_complete, bus.tx_error};
        checks++;
        if (got !== 5'b10000) begin
          fails++;
          $display("FAIL %s after rst: got %b expected 10000", name, got);
        end
        return;
      end
      @(posedge clk); #1;
    end
    bus.load_enable = 1'b0;
    bus.state_val = 3'd0;
    checks++;
    if (bc_seen != bc_exp) begin
      fails++;
      $display("FAIL %s byte_complete count: got %0d expected %0d", name, bc_seen, bc_exp);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b1;
    bus.load_enable = 1'b1;
    bus.data_pts = 8'h00;
    bus.state_val = 3'd6;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.dplus, bus.dminus, bus.tx_active, bus.byte_complete, bus.tx_error};
    checks++;
    if (got !== 5'b10000) begin
      fails++;
      $display("FAIL reset: got %b expected 10000", got);
    end
    bus.load_enable = 1'b0;
    bus.state_val = 3'd0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_eop();
    bytes_q = '{8'h80};
    run_packet("single_80", 1'b1, -1, -1);
  endtask

  task automatic test_stuffing();
    bytes_q = '{8'hFF, 8'hFF};
    run_packet("stuff_ff_ff", 1'b1, 0, -1);
  endtask

  task automatic test_back_to_back();
    bytes_q = '{8'h01, 8'hC3, 8'h5A};
    run_packet("back_to_back", 1'b1, 2, -1);
  endtask

  task automatic test_underrun();
    bytes_q = '{8'h01};
    run_packet("underrun", 1'b0, -1, -1);
  endtask

  task automatic test_idle_eop_ignored();
    bus.state_val = 3'd6;
    repeat (3) @(posedge clk);
    #1;
    bytes_q = '{8'h3C};
    run_packet("idle_eop_ignored", 1'b0, -1, -1);
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 8; p++) begin
      n = int'($urandom_range(1, 4));
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(p % 2 == 0 ? 8'($urandom) : 8'($urandom) | 8'hF0);
      run_packet("random", 1'($urandom), -1, -1);
    end
  endtask

  task automatic test_mid_reset();
    bytes_q = '{8'hFF, 8'hFE, 8'h7F};
    run_packet("mid_reset", 1'b1, 1, 100);
    bytes_q = '{8'h80};
    run_packet("after_reset_80", 1'b1, -1, -1);
  endtask

  initial begin
    bus.load_enable = 1'b0;
    bus.data_pts = 8'h00;
    bus.state_val = 3'd0;
    test_reset();
    test_single_eop();
    test_stuffing();
    test_back_to_back();
    test_underrun();
    test_idle_eop_ignored();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
